// File: rtl/code_ram_bus_arbiter_if.sv
// Bus bundle between the instruction/data bus decoders, the code RAM arbiter and the RAM macro.
// The arbiter uses the slave modport. Bus-side drivers (decoders, RAM model) use the master modport.
interface code_ram_bus_arbiter_if #(
    parameter int ADDR_W = 13
);
    logic              m0_req;
    logic [31:0]       m0_addr;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [31:0]       m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [3:0]        m1_be;
    logic [31:0]       m1_addr;
    logic [31:0]       m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [31:0]       m1_rdata;

    logic              ram_req;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_we, m1_be, m1_addr, m1_wdata, ram_rdata,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        output ram_req, ram_we, ram_be, ram_addr, ram_wdata
    );

    modport master (
        output m0_req, m0_addr, m1_req, m1_we, m1_be, m1_addr, m1_wdata, ram_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        input  ram_req, ram_we, ram_be, ram_addr, ram_wdata
    );
endinterface

// File: rtl/code_ram_bus_arbiter.sv
// Arbitrates the single-port code RAM between instruction bus (M0) and data bus (M1), M1 first.
// Define CODE_RAM_ARB_STARVE_GUARD_EN to let a starved M0 win one cycle after MAX_WAIT denials.
module code_ram_bus_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    code_ram_bus_arbiter_if.slave   bus
);
`ifdef CODE_RAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    owner_e     owner_q, owner_d;
    logic [3:0] m0_wait_q, m0_wait_d;
    logic       force_m0, m0_gnt, m1_gnt;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        force_m0  = GUARD_EN && bus.m0_req && (m0_wait_q == WAIT_LIM);
        m1_gnt    = rst_n & bus.m1_req & ~force_m0;
        m0_gnt    = rst_n & bus.m0_req & ~m1_gnt;

        owner_d = OWN_NONE;
        if (m0_gnt)      owner_d = OWN_M0;
        else if (m1_gnt) owner_d = OWN_M1;

        m0_wait_d = 4'd0;
        if (bus.m0_req && !m0_gnt)
            m0_wait_d = (m0_wait_q == 4'hF) ? m0_wait_q : m0_wait_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_NONE;
            m0_wait_q <= 4'd0;
        end else begin
            owner_q   <= owner_d;
            m0_wait_q <= m0_wait_d;
        end
    end

    always_comb begin
        bus.m0_gnt    = m0_gnt;
        bus.m1_gnt    = m1_gnt;
        bus.ram_req   = m0_gnt | m1_gnt;
        bus.ram_we    = m1_gnt & bus.m1_we;
        bus.ram_be    = 4'h0;
        bus.ram_wdata = 32'h0;
        bus.ram_addr  = '0;
        if (m1_gnt) begin
            bus.ram_be    = bus.m1_be;
            bus.ram_wdata = bus.m1_wdata;
            bus.ram_addr  = bus.m1_addr[ADDR_W+1:2];
        end else if (m0_gnt) begin
            bus.ram_be    = 4'hF;
            bus.ram_addr  = bus.m0_addr[ADDR_W+1:2];
        end

        // Only the master that owns the in-flight access sees the RAM data.
        bus.m0_rvalid = (owner_q == OWN_M0);
        bus.m1_rvalid = (owner_q == OWN_M1);
        bus.m0_rdata  = bus.m0_rvalid ? bus.ram_rdata : 32'h0;
        bus.m1_rdata  = bus.m1_rvalid ? bus.ram_rdata : 32'h0;
    end

    // Byte-offset and out-of-window address bits are not used by the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.m0_addr[31:ADDR_W+2], bus.m0_addr[1:0],
                                bus.m1_addr[31:ADDR_W+2], bus.m1_addr[1:0]};
endmodule
